// File: rtl/ahbl_tsm_pkg.sv
// Shared types and constants for the AHB-Lite test status monitor:
// status encoding, snooped transfer types and the pass/fail control words.
package ahbl_tsm_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] PASS_CODE_LO = 32'h0000_0fff;
    localparam logic [31:0] PASS_CODE_HI = 32'hffff_0000;
    localparam logic [31:0] FAIL_CODE_LO = 32'h0000_0eee;
    localparam logic [31:0] FAIL_CODE_HI = 32'heeee_0000;

    localparam int CHAR_W = 10;

endpackage

// File: rtl/tsm_char_fifo.sv
// Synchronous FIFO for console characters. A pop and a push in the same
// cycle are accepted even when full, since the pop frees the slot first.
module tsm_char_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_ready,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop   = ~o_empty & i_ready;
    assign w_push  = i_push & (~o_full | w_pop);

    // The head is forced to zero while empty so stale storage never shows.
    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
        end
    end

endmodule

// File: rtl/ahbl_test_status_mon.sv
// Observe-only AHB-Lite snooper turning control-word writes into test
// status, a buffered console stream, a retire watchdog and run counters.
module ahbl_test_status_mon
    import ahbl_tsm_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 32'h6000_fff8,
    parameter int              NUM_CH     = 1,
    parameter int              FIFO_DEPTH = 16,
    parameter int              WDOG_WIN   = 5000,
    parameter logic [31:0]     PC_THRESH  = 32'h0000_0ad4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              retire,
    input  logic [31:0]       retire_pc,
    input  logic              wdog_en,
    output logic              cons_valid,
    input  logic              cons_ready,
    output logic [7:0]        cons_data,
    output logic [1:0]        cons_ch,
    output logic              cons_ovf,
    output logic [1:0]        status,
    output logic [1:0]        status_ch,
    output logic              done,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       inst_cnt
);

    localparam int WIN_W = (WDOG_WIN > 2) ? $clog2(WDOG_WIN) : 1;

    logic              w_addrHit;
    logic [1:0]        w_addrCh;
    logic              r_hit;
    logic [1:0]        r_hitCh;
    logic              w_dataDone;
    logic [31:0]       w_word;
    logic              w_isPass;
    logic              w_isFail;
    logic              w_isChar;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [CHAR_W-1:0] w_fifoData;
    logic              r_ovf;
    logic [WIN_W-1:0]  r_winCnt;
    logic              r_seen;
    logic              w_wrap;
    logic              w_expire;
    status_e           r_status;
    logic [1:0]        r_statusCh;
    logic              r_done;
    logic [31:0]       r_cycleCnt;
    logic [31:0]       r_instCnt;

    always_comb begin
        w_addrHit = 1'b0;
        w_addrCh  = 2'd0;
        if ((htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hwrite) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (haddr == CTRL_ADDR + ADDR_W'(4 * k)) begin
                    w_addrHit = 1'b1;
                    w_addrCh  = 2'(k);
                end
            end
        end
    end

    // Address phase is captured on every ready cycle; a stalled data phase
    // keeps the hit until the bus finally completes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit   <= 1'b0;
            r_hitCh <= 2'd0;
        end else if (hready) begin
            r_hit   <= w_addrHit;
            r_hitCh <= w_addrCh;
        end
    end

    assign w_dataDone = r_hit & hready;
    assign w_word     = hwdata[31:0];
    assign w_isPass   = w_dataDone & ((w_word == PASS_CODE_LO) || (w_word == PASS_CODE_HI));
    assign w_isFail   = w_dataDone & ((w_word == FAIL_CODE_LO) || (w_word == FAIL_CODE_HI));
    assign w_isChar   = w_dataDone & ~w_isPass & ~w_isFail & (r_status == ST_RUN);

    tsm_char_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_isChar),
        .i_pushData ({r_hitCh, hwdata[7:0]}),
        .i_ready    (cons_ready),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty),
        .o_data     (w_fifoData)
    );

    assign cons_valid = ~w_fifoEmpty;
    assign cons_ch    = w_fifoData[9:8];
    assign cons_data  = w_fifoData[7:0];
    assign cons_ovf   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_isChar && w_fifoFull && !(cons_valid && cons_ready)) begin
            r_ovf <= 1'b1;
        end
    end

    // A retire on the wrap cycle still belongs to the window that is closing.
    assign w_wrap   = wdog_en && (r_winCnt == WIN_W'(WDOG_WIN - 1));
    assign w_expire = w_wrap & ~(r_seen | retire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winCnt <= '0;
            r_seen   <= 1'b0;
        end else if (!wdog_en || w_wrap) begin
            r_winCnt <= '0;
            r_seen   <= 1'b0;
        end else begin
            r_winCnt <= r_winCnt + WIN_W'(1);
            r_seen   <= r_seen | retire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= ST_RUN;
            r_statusCh <= 2'd0;
            r_done     <= 1'b0;
        end else if (r_status == ST_RUN) begin
            if (w_isPass) begin
                r_status   <= ST_PASS;
                r_statusCh <= r_hitCh;
                r_done     <= 1'b1;
            end else if (w_isFail) begin
                r_status   <= ST_FAIL;
                r_statusCh <= r_hitCh;
                r_done     <= 1'b1;
            end else if (w_expire) begin
                r_status   <= ST_TIMEOUT;
                r_statusCh <= 2'd0;
                r_done     <= 1'b1;
            end
        end
    end

    assign status    = r_status;
    assign status_ch = r_statusCh;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycleCnt <= '0;
            r_instCnt  <= '0;
        end else begin
            if (r_cycleCnt != 32'hffff_ffff) begin
                r_cycleCnt <= r_cycleCnt + 32'd1;
            end
            if (retire && (retire_pc > PC_THRESH) && (r_instCnt != 32'hffff_ffff)) begin
                r_instCnt <= r_instCnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycleCnt;
    assign inst_cnt  = r_instCnt;

endmodule

// File: tb/tb_ahbl_test_status_mon.sv
// Bench for ahbl_test_status_mon: directed and randomized bus traffic checked
// against a transaction-level model of status, console queue and counters.
module tb_ahbl_test_status_mon;

    localparam int          NUM_CH     = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          WDOG_WIN   = 16;
    localparam logic [31:0] CTRL       = 32'h6000_fff8;
    localparam logic [31:0] PC_THRESH  = 32'h0000_0ad4;
    localparam logic [1:0]  TR_IDLE    = 2'b00;
    localparam logic [1:0]  TR_NONSEQ  = 2'b10;
    localparam logic [1:0]  TR_SEQ     = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = TR_IDLE;
    logic        hwrite = 1'b0;
    logic        hready = 1'b1;
    logic [31:0] hwdata = '0;
    logic        retire = 1'b0;
    logic [31:0] retire_pc = '0;
    logic        wdog_en = 1'b0;
    logic        cons_ready = 1'b0;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic [1:0]  cons_ch;
    logic        cons_ovf;
    logic [1:0]  status;
    logic [1:0]  status_ch;
    logic        done;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    ahbl_test_status_mon #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .CTRL_ADDR  (CTRL),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WDOG_WIN   (WDOG_WIN),
        .PC_THRESH  (PC_THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hready     (hready),
        .hwdata     (hwdata),
        .retire     (retire),
        .retire_pc  (retire_pc),
        .wdog_en    (wdog_en),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready),
        .cons_data  (cons_data),
        .cons_ch    (cons_ch),
        .cons_ovf   (cons_ovf),
        .status     (status),
        .status_ch  (status_ch),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: expected console queue, status and counters.
    logic [9:0]  expQ [$];
    int          expStatus;
    int          expStatusCh;
    bit          expOvf;
    longint      mCycle;
    longint      mInst;
    int          mWinPos;
    bit          mSeen;
    bit          mWrValid;
    logic [1:0]  mWrCh;
    logic [31:0] mWrData;
    int          numAssert = 0;
    int          numFail = 0;

    function automatic bit isCode(input logic [31:0] d);
        return (d == 32'h0000_0fff) || (d == 32'hffff_0000) ||
               (d == 32'h0000_0eee) || (d == 32'heeee_0000);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numAssert++;
        assert (obs === exp) else begin
            numFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string where);
        checkOutput({where, ":status"},    32'(status),     32'(expStatus));
        checkOutput({where, ":status_ch"}, 32'(status_ch),  32'(expStatusCh));
        checkOutput({where, ":done"},      32'(done),       32'(expStatus != 0));
        checkOutput({where, ":ovf"},       32'(cons_ovf),   32'(expOvf));
        checkOutput({where, ":cycle"},     cycle_cnt,       32'(mCycle));
        checkOutput({where, ":inst"},      inst_cnt,        32'(mInst));
        checkOutput({where, ":valid"},     32'(cons_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkOutput({where, ":data"}, 32'(cons_data), 32'(expQ[0][7:0]));
            checkOutput({where, ":ch"},   32'(cons_ch),   32'(expQ[0][9:8]));
        end
    endtask

    task automatic checkReset(input string where);
        checkOutput({where, ":status"},    32'(status),     32'd0);
        checkOutput({where, ":status_ch"}, 32'(status_ch),  32'd0);
        checkOutput({where, ":done"},      32'(done),       32'd0);
        checkOutput({where, ":valid"},     32'(cons_valid), 32'd0);
        checkOutput({where, ":data"},      32'(cons_data),  32'd0);
        checkOutput({where, ":ch"},        32'(cons_ch),    32'd0);
        checkOutput({where, ":ovf"},       32'(cons_ovf),   32'd0);
        checkOutput({where, ":cycle"},     cycle_cnt,       32'd0);
        checkOutput({where, ":inst"},      inst_cnt,        32'd0);
    endtask

    // Advance one clock, first applying the spec rules for this cycle to the model.
    task automatic clockCycle();
        bit expire;
        bit seenNow;
        expire = 1'b0;
        if (cons_ready && expQ.size() > 0) begin
            checkOutput("pop:valid", 32'(cons_valid), 32'd1);
            checkOutput("pop:data",  32'(cons_data),  32'(expQ[0][7:0]));
            checkOutput("pop:ch",    32'(cons_ch),    32'(expQ[0][9:8]));
            void'(expQ.pop_front());
        end
        if (wdog_en) begin
            seenNow = mSeen || retire;
            if (mWinPos == WDOG_WIN - 1) begin
                expire  = !seenNow;
                mWinPos = 0;
                mSeen   = 1'b0;
            end else begin
                mWinPos++;
                mSeen = seenNow;
            end
        end else begin
            mWinPos = 0;
            mSeen   = 1'b0;
        end
        if (mWrValid && expStatus == 0) begin
            if (mWrData == 32'h0000_0fff || mWrData == 32'hffff_0000) begin
                expStatus   = 1;
                expStatusCh = int'(mWrCh);
            end else if (mWrData == 32'h0000_0eee || mWrData == 32'heeee_0000) begin
                expStatus   = 2;
                expStatusCh = int'(mWrCh);
            end else if (expQ.size() < FIFO_DEPTH) begin
                expQ.push_back({mWrCh, mWrData[7:0]});
            end else begin
                expOvf = 1'b1;
            end
        end
        if (expire && expStatus == 0) begin
            expStatus   = 3;
            expStatusCh = 0;
        end
        if (mCycle < 64'h0000_0000_ffff_ffff) mCycle++;
        if (retire && retire_pc > PC_THRESH && mInst < 64'h0000_0000_ffff_ffff) mInst++;
        @(posedge clk);
        #1;
        mWrValid = 1'b0;
    endtask

    task automatic modelClear();
        expQ.delete();
        expStatus   = 0;
        expStatusCh = 0;
        expOvf      = 1'b0;
        mCycle      = 0;
        mInst       = 0;
        mWinPos     = 0;
        mSeen       = 1'b0;
        mWrValid    = 1'b0;
    endtask

    task automatic doReset(input string where);
        rst = 1'b1;
        #2;
        checkReset(where);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear();
    endtask

    // One snooped transfer: address phase, optional data-phase stalls, completion.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans, input bit wr,
                                 input logic [31:0] data, input int stalls, input bit readyAtEnd);
        bit hit;
        hit = (trans == TR_NONSEQ || trans == TR_SEQ) && wr && (addr >= CTRL) &&
              (addr < CTRL + 32'(4 * NUM_CH)) && (addr[1:0] == CTRL[1:0]);
        haddr  = addr;
        htrans = trans;
        hwrite = wr;
        hready = 1'b1;
        hwdata = $urandom;
        clockCycle();
        haddr  = '0;
        htrans = TR_IDLE;
        hwrite = 1'b0;
        hwdata = data;
        for (int s = 0; s < stalls; s++) begin
            hready = 1'b0;
            clockCycle();
            checkState("stall");
        end
        hready = 1'b1;
        if (hit) begin
            mWrValid = 1'b1;
            mWrCh    = 2'((addr - CTRL) >> 2);
            mWrData  = data;
        end
        if (readyAtEnd) cons_ready = 1'b1;
        clockCycle();
        if (readyAtEnd) cons_ready = 1'b0;
        hwdata = $urandom;
    endtask

    task automatic charWrite(input int ch, input int stalls);
        logic [31:0] d;
        d = $urandom;
        if (isCode(d)) d = d ^ 32'h0001_0000;
        applyStimulus(CTRL + 32'(4 * ch), ($urandom_range(0, 1) != 0) ? TR_SEQ : TR_NONSEQ,
                      1'b1, d, stalls, 1'b0);
    endtask

    task automatic drainAll(input string where);
        cons_ready = 1'b1;
        for (int n = 0; n < FIFO_DEPTH + 4 && expQ.size() > 0; n++) begin
            clockCycle();
            checkState(where);
        end
        checkOutput({where, ":empty"}, 32'(cons_valid), 32'd0);
        cons_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] pcs [5];
        int          r;
        modelClear();
        #1;
        $display("[TB] reset");
        doReset("reset");
        checkState("reset");

        $display("[TB] console characters on channel 0");
        cons_ready = 1'b1;
        applyStimulus(CTRL, TR_NONSEQ, 1'b1, 32'h0000_0048, 0, 1'b0);
        checkState("c48");
        checkOutput("c48:data", 32'(cons_data), 32'h48);
        checkOutput("c48:ch",   32'(cons_ch),   32'h0);
        applyStimulus(CTRL, TR_NONSEQ, 1'b1, 32'h0000_0069, 0, 1'b0);
        checkState("c69");
        checkOutput("c69:data", 32'(cons_data), 32'h69);
        applyStimulus(CTRL + 32'd4, TR_NONSEQ, 1'b1, 32'h1000_0fff, 0, 1'b0);
        checkState("nearpass");
        applyStimulus(CTRL + 32'd8, TR_NONSEQ, 1'b1, 32'hffff_0001, 0, 1'b0);
        checkState("nearpass2");
        applyStimulus(CTRL + 32'd12, TR_SEQ, 1'b1, 32'h0000_0eef, 1, 1'b0);
        checkState("nearfail");
        drainAll("drain1");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            cons_ready = ($urandom_range(0, 1) != 0);
            if (r < 6) begin
                charWrite($urandom_range(0, NUM_CH - 1), $urandom_range(0, 2));
            end else if (r == 6) begin
                applyStimulus(CTRL + 32'(4 * $urandom_range(0, NUM_CH - 1)), TR_NONSEQ, 1'b0,
                              32'h0000_0fff, 0, 1'b0);
            end else if (r == 7) begin
                applyStimulus(CTRL, 2'($urandom_range(0, 1)), 1'b1, 32'h0000_0fff, 0, 1'b0);
            end else if (r == 8) begin
                applyStimulus(CTRL + 32'(4 * NUM_CH), TR_NONSEQ, 1'b1, 32'h0000_0eee, 0, 1'b0);
            end else begin
                applyStimulus(CTRL - 32'd4, TR_SEQ, 1'b1, 32'h0000_0fff, 0, 1'b0);
            end
            checkState("rand");
        end
        drainAll("drain2");

        $display("[TB] overflow with five writes into four entries");
        cons_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            charWrite(i % NUM_CH, 0);
            checkState("fill");
        end
        checkOutput("ovf:set", 32'(cons_ovf), 32'd1);
        cons_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clockCycle();
            checkState("out4");
        end
        checkOutput("out4:valid3", 32'(cons_valid), 32'd1);
        clockCycle();
        checkOutput("out4:valid4", 32'(cons_valid), 32'd0);
        cons_ready = 1'b0;

        $display("[TB] pop and push in the same cycle while full");
        for (int i = 0; i < FIFO_DEPTH; i++) charWrite(3 - i, 0);
        checkState("full");
        applyStimulus(CTRL + 32'd4, TR_NONSEQ, 1'b1, 32'h0000_005a, 0, 1'b1);
        checkState("popPush");
        drainAll("drain3");

        $display("[TB] retire counting");
        pcs[0] = 32'h0ad0; pcs[1] = 32'h0ad4; pcs[2] = 32'h0ad8; pcs[3] = 32'h1000; pcs[4] = 32'h0ad5;
        for (int i = 0; i < 4; i++) begin
            retire = 1'b1;
            retire_pc = pcs[i];
            clockCycle();
        end
        retire = 1'b0;
        checkOutput("inst:two", inst_cnt, 32'd2);
        retire = 1'b1;
        retire_pc = pcs[4];
        clockCycle();
        retire = 1'b0;
        checkOutput("inst:three", inst_cnt, 32'd3);
        for (int i = 0; i < 20; i++) begin
            retire = ($urandom_range(0, 1) != 0);
            retire_pc = 32'($urandom_range(32'h0a00, 32'h0b00));
            clockCycle();
            checkState("retire");
        end
        retire = 1'b0;

        $display("[TB] fail word on channel 3 with stalled data phase");
        for (int i = 0; i < 3; i++) charWrite(i, 0);
        applyStimulus(CTRL + 32'd12, TR_NONSEQ, 1'b1, 32'heeee_0000, 2, 1'b0);
        checkState("fail");
        checkOutput("fail:status", 32'(status),    32'd2);
        checkOutput("fail:ch",     32'(status_ch), 32'd3);
        applyStimulus(CTRL, TR_NONSEQ, 1'b1, 32'h0000_0fff, 0, 1'b0);
        checkOutput("fail:sticky", 32'(status), 32'd2);
        applyStimulus(CTRL + 32'd4, TR_NONSEQ, 1'b1, 32'h0000_0041, 0, 1'b0);
        checkState("ignored");
        cons_ready = 1'b1;
        clockCycle();
        checkState("termDrain");
        cons_ready = 1'b0;

        $display("[TB] reset with three characters queued");
        doReset("rst1");
        for (int i = 0; i < 3; i++) charWrite(i, 0);
        checkState("queued3");
        doReset("rst2");
        checkState("afterRst");

        $display("[TB] pass word on channel 0");
        applyStimulus(CTRL, TR_NONSEQ, 1'b1, 32'h0000_0fff, 0, 1'b0);
        checkState("pass");
        checkOutput("pass:status", 32'(status),    32'd1);
        checkOutput("pass:done",   32'(done),      32'd1);
        checkOutput("pass:ch",     32'(status_ch), 32'd0);
        doReset("rst3");

        $display("[TB] watchdog disabled");
        wdog_en = 1'b0;
        for (int i = 0; i < 40; i++) clockCycle();
        checkState("wdOff");
        checkOutput("wdOff:status", 32'(status), 32'd0);

        $display("[TB] watchdog with one retire in the first window");
        wdog_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            retire = (i == 10);
            retire_pc = 32'h0000_2000;
            clockCycle();
            checkState("wd");
            if (i == 31) checkOutput("wd:run31", 32'(status), 32'd0);
            if (i == 32) checkOutput("wd:timeout32", 32'(status), 32'd3);
        end
        retire = 1'b0;
        applyStimulus(CTRL + 32'd8, TR_NONSEQ, 1'b1, 32'h0000_0fff, 0, 1'b0);
        checkOutput("wd:sticky", 32'(status), 32'd3);
        checkOutput("wd:ch",     32'(status_ch), 32'd0);

        $display("[TB] pass word coinciding with watchdog expiry");
        doReset("rst4");
        wdog_en = 1'b1;
        for (int i = 0; i < WDOG_WIN - 2; i++) clockCycle();
        applyStimulus(CTRL + 32'd8, TR_NONSEQ, 1'b1, 32'h0000_0fff, 0, 1'b0);
        checkState("race");
        checkOutput("race:status", 32'(status),    32'd1);
        checkOutput("race:ch",     32'(status_ch), 32'd2);
        wdog_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", numAssert, numFail);
        $finish;
    end

endmodule
